// File: rtl/trace_scheduler_if.sv
// Tracer start/done handshake plus trace_buffer write port, grouped for the scheduler.
// master = scheduler side, slave = tracer/buffer side.
interface trace_scheduler_if #(
    parameter int HEIGHT_W = 8
);
    logic                trc_start;
    logic [9:0]          trc_column;
    logic                trc_done;
    logic                trc_side;
    logic [HEIGHT_W-1:0] trc_height;
    logic                buf_we;
    logic [9:0]          buf_addr;
    logic                buf_side;
    logic [HEIGHT_W-1:0] buf_height;

    modport master (
        output trc_start, trc_column, buf_we, buf_addr, buf_side, buf_height,
        input  trc_done, trc_side, trc_height
    );

    modport slave (
        input  trc_start, trc_column, buf_we, buf_addr, buf_side, buf_height,
        output trc_done, trc_side, trc_height
    );
endinterface

// File: rtl/trace_scheduler.sv
// VBLANK column-trace sequencer: issue, wait for tracer, commit to trace_buffer.
// Optional TRACE_SCHED_HALFRES_EN traces even columns only and writes each result twice.
module trace_scheduler #(
    parameter int START_COL = 0,
    parameter int END_COL   = 639,
    parameter int HEIGHT_W  = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    trace_scheduler_if.master   bus,
    output logic                frame_done,
    output logic                overrun,
    output logic                timeout_seen
);
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [9:0]        LAST_COL  = 10'(END_COL);
`ifdef TRACE_SCHED_HALFRES_EN
    localparam logic [9:0]        FIRST_COL = 10'(START_COL) & 10'h3FE;
`else
    localparam logic [9:0]        FIRST_COL = 10'(START_COL);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE,
`ifdef TRACE_SCHED_HALFRES_EN
        STORE2,
`endif
        DONE
    } state_t;

    state_t              state_reg;
    logic [1:0]          rst_sync_reg;
    logic [9:0]          col_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic                enable_reg;
    logic                enable_rise_reg;
    logic                trc_start_reg;
    logic                buf_we_reg;
    logic [9:0]          buf_addr_reg;
    logic                buf_side_reg;
    logic [HEIGHT_W-1:0] buf_height_reg;
    logic                frame_done_reg;
    logic                overrun_reg;
    logic                timeout_seen_reg;
    logic                sweeping;
`ifdef TRACE_SCHED_HALFRES_EN
    logic [10:0]         col_plus1;
    logic [10:0]         col_plus2;

    assign col_plus1 = {1'b0, col_reg} + 11'd1;
    assign col_plus2 = {1'b0, col_reg} + 11'd2;
`endif

    assign sweeping = (state_reg != IDLE) && (state_reg != DONE);

    // Reset assertion is immediate; release reaches the FSM two clocks later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            col_reg          <= FIRST_COL;
            wait_cnt_reg     <= '0;
            enable_reg       <= 1'b0;
            enable_rise_reg  <= 1'b0;
            trc_start_reg    <= 1'b0;
            buf_we_reg       <= 1'b0;
            buf_addr_reg     <= '0;
            buf_side_reg     <= 1'b0;
            buf_height_reg   <= '0;
            frame_done_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
            timeout_seen_reg <= 1'b0;
        end else if (rst_sync_reg[1]) begin
            enable_reg      <= enable;
            enable_rise_reg <= enable & ~enable_reg;
            trc_start_reg   <= 1'b0;
            buf_we_reg      <= 1'b0;
            frame_done_reg  <= 1'b0;

            // Losing the window mid-sweep abandons it; col keeps the aborted column.
            if (sweeping && !enable_reg) begin
                state_reg   <= IDLE;
                overrun_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (enable_rise_reg) begin
                            col_reg          <= FIRST_COL;
                            overrun_reg      <= 1'b0;
                            timeout_seen_reg <= 1'b0;
                            trc_start_reg    <= 1'b1;
                            state_reg        <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end
                    WAIT: begin
                        if (bus.trc_done) begin
                            buf_we_reg     <= 1'b1;
                            buf_addr_reg   <= col_reg;
                            buf_side_reg   <= bus.trc_side;
                            buf_height_reg <= bus.trc_height;
                            state_reg      <= STORE;
                        end else if (wait_cnt_reg == WAIT_LAST) begin
                            // Dead column: zero height renders as the error colour.
                            buf_we_reg       <= 1'b1;
                            buf_addr_reg     <= col_reg;
                            buf_side_reg     <= 1'b0;
                            buf_height_reg   <= '0;
                            timeout_seen_reg <= 1'b1;
                            state_reg        <= STORE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
                        end
                    end
`ifdef TRACE_SCHED_HALFRES_EN
                    STORE: begin
                        if (col_plus1 <= {1'b0, LAST_COL}) begin
                            buf_we_reg   <= 1'b1;
                            buf_addr_reg <= col_plus1[9:0];
                            state_reg    <= STORE2;
                        end else begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= DONE;
                        end
                    end
                    STORE2: begin
                        if (col_plus2 > {1'b0, LAST_COL}) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            col_reg       <= col_plus2[9:0];
                            trc_start_reg <= 1'b1;
                            state_reg     <= ISSUE;
                        end
                    end
`else
                    STORE: begin
                        if (col_reg == LAST_COL) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            col_reg       <= col_reg + 10'd1;
                            trc_start_reg <= 1'b1;
                            state_reg     <= ISSUE;
                        end
                    end
`endif
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.trc_start  = trc_start_reg;
    assign bus.trc_column = col_reg;
    assign bus.buf_we     = buf_we_reg;
    assign bus.buf_addr   = buf_addr_reg;
    assign bus.buf_side   = buf_side_reg;
    assign bus.buf_height = buf_height_reg;
    assign frame_done     = frame_done_reg;
    assign overrun        = overrun_reg;
    assign timeout_seen   = timeout_seen_reg;
endmodule
